uart_rx_wb: RTL and testbench

UART_RX_WB -- requirements
Module: uart_rx_wb

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_rx_fifo.sv | 58 +++++
 rtl/uart_rx_wb.sv | 251 +++++++++++++++++++++++++
 tb/tb_uart_rx_wb.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg - shared definitions for the Wishbone UART receiver.
// Register offsets, STATUS bit positions, receiver FSM states, data width.
// Optional build macro: UART_RX_PARITY_EN (adds the PARITY state for 8E1).
package uart_pkg;

  localparam int DATA_W = 8;

  // Register select values, taken from wb_adr[3:2]
  localparam logic [1:0] REG_RXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // STATUS / CTRL bit positions
  localparam int STAT_NOT_EMPTY  = 0;
  localparam int STAT_FULL       = 1;
  localparam int STAT_OVERRUN    = 2;
  localparam int STAT_FRAME_ERR  = 3;
  localparam int STAT_PARITY_ERR = 4;
  localparam int STAT_COUNT_LSB  = 8;

  // state    | meaning
  // S_IDLE   | line idle, waiting for a synchronized falling edge
  // S_START  | half-bit wait, then confirm the start bit is still low
  // S_DATA   | eight data samples, LSB first, one bit period apart
  // S_PARITY | even-parity sample (parity builds only)
  // S_STOP   | stop-bit sample, decides push / frame error
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } rx_state_t;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo - receive FIFO, power-of-two depth, pointers wrap naturally.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = DATA_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & (~o_full | i_pop);
  assign w_do_pop  = i_pop & ~o_empty;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy is tracked separately
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/uart_rx_wb.sv
// uart_rx_wb - UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined)
// with a receive FIFO and a Wishbone register interface.
// Start bit is confirmed DIV/2 cycles after the synchronized falling edge;
// later samples follow at DIV-cycle intervals. Frame results (push / errors)
// are registered one cycle after the stop-bit sample.
module uart_rx_wb
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack,
  input  logic        uart_rx,
  output logic        irq
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  // Start wait is loaded two short: one cycle is spent entering S_START,
  // one in the terminal-count compare, so the sample lands DIV/2 after the edge.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV - 1);

  logic              r_sync1, r_sync2, r_sync_d;
  logic              w_fall;
  rx_state_t         r_state;
  logic [CNT_W-1:0]  r_baud_cnt;
  logic [2:0]        r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_push;
  logic              r_frame_evt;
  logic              r_overrun, r_frame_err;
  logic              w_parity_err;
  logic              w_full, w_empty, w_pop, w_overrun_evt;
  logic [DATA_W-1:0] w_fifo_data;
  logic [CW-1:0]     w_count;
  logic              w_req, w_rd, w_wr;
  logic [1:0]        w_sel;
  logic [2:0]        w_clr;
  logic [31:0]       w_status;
  logic              r_ack, r_pop_pend;
  logic [31:0]       r_dat_o;
  logic              w_unused;

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_parity_evt;
  logic r_parity_err;
`endif

  assign w_unused = ^{wb_adr[31:4], wb_adr[1:0], wb_dat_i[31:5], wb_dat_i[1:0]};

  // Two-flop synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_sync_d <= 1'b1;
    end else begin
      r_sync1  <= uart_rx;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  assign w_fall = r_sync_d & ~r_sync2;

  // Receive FSM: down-counter timing, shift register, registered frame results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_baud_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_frame_evt <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= 1'b0;
      r_parity_evt <= 1'b0;
`endif
    end else begin
      r_push      <= 1'b0;
      r_frame_evt <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_evt <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state    <= S_START;
            r_baud_cnt <= HALF_LOAD;
          end
        end
        S_START: begin
          if (r_baud_cnt != '0) begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end else if (!r_sync2) begin
            r_state    <= S_DATA;
            r_baud_cnt <= DIV_LOAD;
            r_bit_cnt  <= 3'd7;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (r_baud_cnt != '0) begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end else begin
            r_shift    <= {r_sync2, r_shift[DATA_W-1:1]};
            r_baud_cnt <= DIV_LOAD;
            if (r_bit_cnt == 3'd0) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt - 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_baud_cnt != '0) begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end else begin
            r_par_bad    <= (r_sync2 != even_parity(r_shift));
            r_parity_evt <= (r_sync2 != even_parity(r_shift));
            r_baud_cnt   <= DIV_LOAD;
            r_state      <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (r_baud_cnt != '0) begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end else begin
            r_state <= S_IDLE;
            if (r_sync2) begin
`ifdef UART_RX_PARITY_EN
              r_push <= ~r_par_bad;
`else
              r_push <= 1'b1;
`endif
            end else begin
              r_frame_evt <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (r_push),
    .i_pop   (w_pop),
    .i_data  (r_shift),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // A full FIFO only overflows when no pop frees a slot in the same cycle
  assign w_overrun_evt = r_push & w_full & ~w_pop;

  assign w_req = wb_cyc & wb_stb & ~r_ack;
  assign w_rd  = w_req & ~wb_we;
  assign w_wr  = w_req & wb_we;
  assign w_sel = wb_adr[3:2];
  assign w_clr = (w_wr && (w_sel == REG_CTRL)) ? wb_dat_i[4:2] : 3'b000;
  // Pop only reads that saw a non-empty FIFO when the data was latched
  assign w_pop = r_ack & r_pop_pend;

  // Sticky flags; a new event wins over a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overrun   <= (r_overrun & ~w_clr[0]) | w_overrun_evt;
      r_frame_err <= (r_frame_err & ~w_clr[1]) | r_frame_evt;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Sticky parity error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_parity_err <= 1'b0;
    else     r_parity_err <= (r_parity_err & ~w_clr[2]) | r_parity_evt;
  end
  assign w_parity_err = r_parity_err;
`else
  assign w_parity_err = 1'b0;
`endif

  // STATUS word assembly
  always_comb begin
    w_status = '0;
    w_status[STAT_NOT_EMPTY]  = ~w_empty;
    w_status[STAT_FULL]       = w_full;
    w_status[STAT_OVERRUN]    = r_overrun;
    w_status[STAT_FRAME_ERR]  = r_frame_err;
    w_status[STAT_PARITY_ERR] = w_parity_err;
    w_status[STAT_COUNT_LSB +: 8] = 8'(w_count);
  end

  // Wishbone ack and registered read data, valid in the ack cycle only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack      <= 1'b0;
      r_dat_o    <= '0;
      r_pop_pend <= 1'b0;
    end else begin
      r_ack      <= w_req;
      r_dat_o    <= '0;
      r_pop_pend <= 1'b0;
      if (w_rd) begin
        case (w_sel)
          REG_RXDATA: begin
            if (!w_empty) begin
              r_dat_o    <= {{(32-DATA_W){1'b0}}, w_fifo_data};
              r_pop_pend <= 1'b1;
            end
          end
          REG_STATUS: r_dat_o <= w_status;
          default:    r_dat_o <= '0;
        endcase
      end
    end
  end

  assign wb_ack   = r_ack;
  assign wb_dat_o = r_dat_o;
  assign irq      = ~w_empty;

endmodule

// File: tb/tb_uart_rx_wb.sv
// tb_uart_rx_wb - directed self-checking bench for uart_rx_wb at default
// parameters (DIV=217). Build with UART_RX_PARITY_EN to add the parity test.
module tb_uart_rx_wb;

  localparam int DIV  = 25000000 / 115200;
  localparam int HALF = DIV / 2;
`ifdef UART_RX_PARITY_EN
  localparam int FS = 10;
`else
  localparam int FS = 9;
`endif
  // Edges from frame start until the read request that lands its pop on the push edge
  localparam int S_OFF = HALF + FS * DIV + 2;

  logic        clk, rst;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_i, wb_dat_o;
  logic        wb_ack, uart_rx, irq;
  int          errors, checks;
`ifdef UART_RX_PARITY_EN
  logic        par_flip;
`endif

  uart_rx_wb dut (
    .clk(clk), .rst(rst), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack),
    .uart_rx(uart_rx), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] data);
    bit got;
    got = 0;
    data = '0;
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = adr;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (wb_ack) begin got = 1; data = wb_dat_o; end
    end
    wb_cyc = 0; wb_stb = 0;
    @(posedge clk); #1;
    checks++;
    if (!got) begin errors++; $display("FAIL rd_ack adr=%h: ack=0 required=1", adr); end
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] data);
    bit got;
    got = 0;
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = adr; wb_dat_i = data;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (wb_ack) got = 1;
    end
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
    @(posedge clk); #1;
    checks++;
    if (!got) begin errors++; $display("FAIL wr_ack adr=%h: ack=0 required=1", adr); end
  endtask

  task automatic drive_bit(input logic b);
    uart_rx = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(posedge clk); #1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
    drive_bit(stop);
    uart_rx = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", wb_ack); end
    checks++; if (wb_dat_o !== 32'h0) begin errors++; $display("FAIL rst_dat: got %h want 0", wb_dat_o); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", irq); end
    rst = 1'b0;
    @(posedge clk); #1;
    wb_read(32'h4, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_status: got %h want 0", rd); end
    wb_read(32'h0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL empty_read: got %h want 0", rd); end
    wb_read(32'h4, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL no_underflow: got %h want 0", rd); end
  endtask

  task automatic test_single();
    logic [31:0] rd;
    send_frame(8'hA5, 1'b1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL single_irq: got %b want 1", irq); end
    wb_read(32'h4, rd);
    checks++; if (rd !== 32'h0101) begin errors++; $display("FAIL single_status: got %h want 0101", rd); end
    wb_read(32'h0, rd);
    checks++; if (rd !== 32'hA5) begin errors++; $display("FAIL single_data: got %h want a5", rd); end
    wb_read(32'h4, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL single_status2: got %h want 0", rd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq2: got %b want 0", irq); end
  endtask

  task automatic test_regmap();
    logic [31:0] rd;
    wb_write(32'h0, 32'hFFFF_FFFF);
    wb_write(32'h4, 32'hFFFF_FFFF);
    wb_write(32'hC, 32'hFFFF_FFFF);
    wb_read(32'h8, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ctrl_read: got %h want 0", rd); end
    wb_read(32'hC, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rsvd_read: got %h want 0", rd); end
    wb_read(32'h4, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ro_write: got %h want 0", rd); end
    // Held strobe: ack pattern 0,1,0,1
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h4;
    checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL ack_c0: got %b want 0", wb_ack); end
    @(posedge clk); #1;
    checks++; if (wb_ack !== 1'b1) begin errors++; $display("FAIL ack_c1: got %b want 1", wb_ack); end
    @(posedge clk); #1;
    checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL ack_c2: got %b want 0", wb_ack); end
    @(posedge clk); #1;
    checks++; if (wb_ack !== 1'b1) begin errors++; $display("FAIL ack_c3: got %b want 1", wb_ack); end
    wb_cyc = 0; wb_stb = 0;
    @(posedge clk); #1;
    checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL ack_c4: got %b want 0", wb_ack); end
  endtask

  task automatic test_overrun();
    logic [31:0] rd;
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
    wb_read(32'h4, rd);
    checks++; if (rd !== 32'h1007) begin errors++; $display("FAIL ovr_status: got %h want 1007", rd); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ovr_irq: got %b want 1", irq); end
    wb_write(32'h8, 32'h4);
    wb_read(32'h4, rd);
    checks++; if (rd !== 32'h1003) begin errors++; $display("FAIL ovr_clear: got %h want 1003", rd); end
  endtask

  task automatic test_full_pushpop();
    logic [31:0] rd;
    logic [31:0] exp;
    logic        ack_seen;
    rd = '0; ack_seen = 1'b0;
    fork
      send_frame(8'h11, 1'b1);
      begin
        repeat (S_OFF) @(posedge clk);
        #1;
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h0;
        @(posedge clk); #1;
        ack_seen = wb_ack;
        rd = wb_dat_o;
        wb_cyc = 0; wb_stb = 0;
      end
    join
    checks++; if (ack_seen !== 1'b1) begin errors++; $display("FAIL pp_ack: got %b want 1", ack_seen); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL pp_data: got %h want 0", rd); end
    wb_read(32'h4, rd);
    checks++; if (rd !== 32'h1003) begin errors++; $display("FAIL pp_status: got %h want 1003", rd); end
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 32'(i + 1) : 32'h11;
      wb_read(32'h0, rd);
      checks++; if (rd !== exp) begin errors++; $display("FAIL pp_order[%0d]: got %h want %h", i, rd, exp); end
    end
    wb_read(32'h4, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL pp_drained: got %h want 0", rd); end
  endtask

  task automatic test_frame_err();
    logic [31:0] rd;
    send_frame(8'h3C, 1'b0);
    wb_read(32'h4, rd);
    checks++; if (rd !== 32'h0008) begin errors++; $display("FAIL ferr_status: got %h want 0008", rd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ferr_irq: got %b want 0", irq); end
    // Low pulse one cycle shorter than the half-bit time must be ignored
    @(posedge clk); #1;
    uart_rx = 1'b0;
    repeat (HALF - 1) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (2 * DIV) @(posedge clk);
    #1;
    wb_read(32'h4, rd);
    checks++; if (rd !== 32'h0008) begin errors++; $display("FAIL glitch_status: got %h want 0008", rd); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] rd;
    logic [7:0]  d;
    send_frame(8'h33, 1'b1);
    wb_read(32'h4, rd);
    checks++; if (rd !== 32'h0109) begin errors++; $display("FAIL mr_pre: got %h want 0109", rd); end
    d = 8'h5A;
    @(posedge clk); #1;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    uart_rx = d[4];
    repeat (HALF) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL mr_ack: got %b want 0", wb_ack); end
    checks++; if (wb_dat_o !== 32'h0) begin errors++; $display("FAIL mr_dat: got %h want 0", wb_dat_o); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mr_irq: got %b want 0", irq); end
    repeat (3) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    rst = 1'b0;
    repeat (2 * DIV) @(posedge clk);
    #1;
    wb_read(32'h4, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mr_status: got %h want 0", rd); end
    send_frame(8'h5A, 1'b1);
    wb_read(32'h0, rd);
    checks++; if (rd !== 32'h5A) begin errors++; $display("FAIL mr_data: got %h want 5a", rd); end
    wb_read(32'h4, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mr_after: got %h want 0", rd); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [31:0] rd;
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    wb_read(32'h4, rd);
    checks++; if (rd !== 32'h0010) begin errors++; $display("FAIL par_bad: got %h want 0010", rd); end
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    wb_read(32'h4, rd);
    checks++; if (rd !== 32'h0111) begin errors++; $display("FAIL par_good: got %h want 0111", rd); end
    wb_read(32'h0, rd);
    checks++; if (rd !== 32'h07) begin errors++; $display("FAIL par_data: got %h want 07", rd); end
  endtask
`endif

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; uart_rx = 1'b1;
    wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = '0; wb_dat_i = '0;
`ifdef UART_RX_PARITY_EN
    par_flip = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_regmap();
    test_overrun();
    test_full_pushpop();
    test_frame_err();
    test_mid_reset();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
